// File: rtl/serial_comp_pkg.sv
// Shared types for the serial two's-complement sequencer.
package serial_comp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef logic mode_t;

    localparam int MAX_WIDTH = 32;

    // Most-negative two's-complement pattern for a w-bit word.
    function automatic logic [MAX_WIDTH-1:0] most_neg(input int w);
        return MAX_WIDTH'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/serial_twos_core.sv
// Bit-serial two's-complement core: copy up to the first 1, invert after it.
module serial_twos_core
    import serial_comp_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  bit_in,
    input  mode_t sel,
    output logic  bit_out
);

    logic seen_q;
    logic seen_d;

    always_comb begin
        seen_d = seen_q | bit_in;
        if (clr) begin
            seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            seen_q <= 1'b0;
        end else begin
            seen_q <= seen_d;
        end
    end

    assign bit_out = (sel && seen_q) ? ~bit_in : bit_in;

endmodule

// File: rtl/serial_comp_ctrl.sv
// Word-level sequencer streaming operands LSB-first through serial_twos_core.
module serial_comp_ctrl
    import serial_comp_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_negate,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mode_t            mode_q, mode_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             core_clr;
    logic             core_bit;

    serial_twos_core u_core (
        .clk     (clk),
        .rst     (rst),
        .clr     (core_clr),
        .bit_in  (shreg_q[0]),
        .sel     (mode_q),
        .bit_out (core_bit)
    );

    assign in_ready  = (state_q == IDLE) && rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = result_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        core_clr    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    shreg_d  = in_data;
                    mode_d   = in_negate;
                    ovf_d    = in_negate && (in_data == MOST_NEG);
                    cnt_d    = '0;
                    core_clr = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d  = shreg_q >> 1;
                result_d = {core_bit, result_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Directed and randomized self-checking bench for serial_comp_ctrl.
module tb_serial_comp_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_negate = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_ovf;
    logic         busy;

    int checks = 0;
    int errors = 0;

    serial_comp_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_negate (in_negate),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_out(input logic [W-1:0] d, input logic n);
        int v;
        v = n ? ((1 << W) - int'(d)) % (1 << W) : int'(d);
        return v[W-1:0];
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] d, input logic n);
        return n && (int'(d) == (1 << (W - 1)));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts just after the acceptance edge; checks latency, result and handshake.
    task automatic wait_result(input logic [W-1:0] d, input logic n, input string tag);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end while (!out_valid && k < 40);
        chk({tag, "_latency"}, 32'(k), 32'(W));
        chk({tag, "_data"}, 32'(out_data), 32'(ref_out(d, n)));
        chk({tag, "_ovf"}, 32'(out_ovf), 32'(ref_ovf(d, n)));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'(0));
        chk({tag, "_idle"}, 32'(busy), 32'(0));
    endtask

    task automatic run_word(input logic [W-1:0] d, input logic n, input string tag);
        int k;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_negate = n;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data   = W'($urandom);
        in_negate = 1'($urandom);
        wait_result(d, n, tag);
    endtask

    initial begin
        logic [W:0]   q[$];
        logic [W:0]   e;
        logic [W-1:0] hold_d;
        int acc;
        int got;
        int cyc;
        int k;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_data", 32'(out_data), 32'(0));
        chk("rst_ovf", 32'(out_ovf), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'(1));

        // Reset during SHIFT aborts the word
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        in_negate = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 32'(1));
        chk("midrst_in_ready_low", 32'(in_ready), 32'(0));
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_valid", 32'(out_valid), 32'(0));
        chk("midrst_data", 32'(out_data), 32'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'(1));
        run_word(8'h01, 1'b1, "after_rst");

        // Directed words
        run_word(8'h06, 1'b1, "neg_06");
        run_word(8'hA5, 1'b0, "pass_a5");
        run_word(8'h00, 1'b1, "neg_00");
        run_word(8'h80, 1'b1, "neg_80");
        run_word(8'hFF, 1'b1, "neg_ff");
        run_word(8'h7F, 1'b1, "neg_7f");
        run_word(8'h80, 1'b0, "pass_80");

        // Backpressure, then back-to-back acceptance
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        in_negate = 1'b1;
        hold_d    = 8'h3C;
        @(posedge clk);
        #1 in_valid = 1'b0;
        k = 0;
        do begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end while (!out_valid && k < 40);
        chk("bp_latency", 32'(k), 32'(W));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'(1));
            chk("bp_data", 32'(out_data), 32'(ref_out(hold_d, 1'b1)));
            chk("bp_ovf", 32'(out_ovf), 32'(0));
            chk("bp_in_ready", 32'(in_ready), 32'(0));
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h80;
        in_negate = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_valid", 32'(out_valid), 32'(0));
        chk("bp_release_idle", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_accept_busy", 32'(busy), 32'(1));
        wait_result(8'h80, 1'b1, "b2b");

        // Random regression against the queue model
        acc = 0;
        got = 0;
        cyc = 0;
        while (got < 1000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (acc < 1000) && ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            in_negate = 1'($urandom);
            out_ready = 1'($urandom);
            if (out_valid && out_ready) begin
                chk("rand_nonempty", 32'(q.size() != 0), 32'(1));
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("rand_data", 32'(out_data), 32'(ref_out(e[W-1:0], e[W])));
                    chk("rand_ovf", 32'(out_ovf), 32'(ref_ovf(e[W-1:0], e[W])));
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back({in_negate, in_data});
                acc++;
            end
            @(posedge clk);
        end
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rand_received", 32'(got), 32'(1000));
        chk("rand_accepted", 32'(acc), 32'(1000));
        chk("rand_leftover", 32'(q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
